video_in_to_axi4_stream: RTL
============================

# video_in_to_axi4_stream

Single-clock capture block that converts a parallel video input (vsync, data enable, pixel data) into an AXI4-Stream master with `tuser` marking start-of-frame and `tlast` marking end-of-line. It is the source-side counterpart of the stream-to-video output stage: camera or timing-driven pixels enter on `video_clk`, are buffered in an internal synchronous FIFO, and are delivered to VDMA/stream consumers on the same clock. Line length is taken from `video_de_i`, so no resolution parameters are needed.

## Interface
- `DW`, 32: pixel/stream data width.
- `FIFO_AW`, 9: FIFO address width; depth = 2^FIFO_AW entries (512).
---
- `video_clk`  in  1  sole clock for video input and AXIS output.
- `video_rst`  in  1  synchronous, active-high reset.
- `video_vsync_i`  in  1  vertical sync; a rising edge marks frame start.
- `video_de_i`  in  1  data enable; high = valid pixel on `video_data_i`.
- `video_data_i`  in  DW  pixel data.
- `m_axis_tdata`  out  DW  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last pixel of line.
- `m_axis_tuser`  out  1  first pixel of frame.
- `fifo_level`  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.
- `overflow`  out  1  sticky: a pixel was dropped because the FIFO was full; cleared only by reset.

## Operation
- Input stage: `video_vsync_i`, `video_de_i`, and `video_data_i` are registered once into `vs_r`, `de_r`, and `data_r`. `vs_r2` delays `vs_r` for edge detection; `vs_rise = vs_r & ~vs_r2`.
- Hold register (one pixel) plus `hold_v`. This lets the final pixel of a line be tagged when DE falls.
  - If `de_r`=1 and `hold_v`=1: write {sof_flag, 0, hold} to the FIFO; `hold` <= `data_r`.
  - If `de_r`=1 and `hold_v`=0: `hold` <= `data_r`; `hold_v` <= 1.
  - If `de_r`=0 and `hold_v`=1: write {sof_flag, 1, hold}; `hold_v` <= 0.
- `sof_flag` is set by `vs_rise` and cleared by the first successful FIFO write after it. That write carries `tuser`=1.
- FSM states:
  - IDLE (reset state): discard all pixels; `hold_v` is held at 0. On `vs_rise`, go to RUN and set `sof_flag`.
  - RUN: hold/write logic is active. A write attempted while the FIFO is full is dropped; set `overflow` and go to DROP.
  - DROP: discard pixels; clear `hold_v`. On `vs_rise`, go to RUN and set `sof_flag`.
- FIFO entries already stored are never flushed on overflow. The consumer resynchronises on the next `tuser`.
- `vs_rise` in RUN while `hold_v`=1 (DE overlapping vsync is not legal timing): the held pixel is still written with the `tlast` rule. `sof_flag` then tags the next write.
- Output: the FIFO is first-word-fall-through. `m_axis_tvalid` = ~empty; {tuser, tlast, tdata} come from the head entry. The head is popped on `tvalid & tready`.
- Simultaneous push and pop at full: the push counts as a write to a full FIFO and is dropped (conservative rule, no bypass).

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `fifo_level`=0, `overflow`=0. FSM=IDLE, `hold_v`=0, `sof_flag`=0.
- Latency, with an empty FIFO and `tready`=1, from the clock edge that samples a pixel with DE high to `tvalid` for that pixel:
  - Every pixel other than the last of a line appears 3 edges later (sample edge, hold edge, write edge), once the next pixel is sampled.
  - The last pixel of a line has the same 3-edge latency, because DE-low sampling triggers its write.
- `vs_rise` is recognised 2 edges after the vsync input rises.
- Throughput: 1 pixel/clock sustained in and out. AXIS output holds data stable while `tvalid` & ~`tready`.
- `fifo_level` updates on the same edge as the push/pop; push & pop together leaves it unchanged.
- Minimum DE-low gap between lines: 1 cycle.

## Structure
- Shared package `vid2axis_pkg`: FSM state enum (IDLE, RUN, DROP), and an entry-width constant = DW+2 with bit positions for tuser and tlast.
- Sub-module `vid2axis_sync_fifo`: single-clock FWFT FIFO with parameters WIDTH and AW, registered level counter, full/empty flags. Top level holds the input stage, hold register, and FSM.

## Test plan
- Reset, then vsync pulse, then 4 lines × 8 pixels (data = line*16+pixel), `tready`=1 → 32 beats, `tuser` only on beat 0 (data 0x00), `tlast` on data 0x07, 0x17, 0x27, 0x37. First `tvalid` occurs 3 edges after the first DE sample.
- Pixels before the first vsync → none are output; the FSM stays IDLE until `vs_rise`.
- Single-pixel lines (DE high 1 cycle, low 1 cycle), 3 lines → 3 beats, each with `tlast`=1; the first has `tuser`=1.
- `tready`=0 with FIFO_AW=4 and a 40-pixel line → 16 entries stored, `fifo_level`=16, `overflow`=1, FSM=DROP. Next frame after draining → `tuser` on its first pixel; `overflow` stays 1.
- Random `tready` (50%) with 2 frames of 64×4 pixels → exact data order preserved, no loss, `fifo_level` never exceeds 2^FIFO_AW.
- `video_rst` asserted mid-line with FIFO holding 10 entries → next edge: `tvalid`=0, `fifo_level`=0, FSM=IDLE.

Source files
------------

// File: rtl/vid2axis_pkg.sv
// Shared definitions for the video-in to AXI4-Stream capture block.
//   - state_t     : capture FSM states (IDLE, RUN, DROP)
//   - ENTRY_W     : FIFO entry width for the default 32-bit pixel
//   - entry_w()   : FIFO entry width for any pixel width (DW + 2)
//   - tlast_bit() : position of the end-of-line flag in an entry
//   - tuser_bit() : position of the start-of-frame flag in an entry
// Entry layout: {tuser, tlast, tdata[DW-1:0]}.
package vid2axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DW_DEFAULT  = 32;
    localparam int ENTRY_EXTRA = 2;
    localparam int ENTRY_W     = DW_DEFAULT + ENTRY_EXTRA;

    function automatic int entry_w(input int dw);
        return dw + ENTRY_EXTRA;
    endfunction

    function automatic int tlast_bit(input int dw);
        return dw;
    endfunction

    function automatic int tuser_bit(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/vid2axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_din : write request and entry; ignored while full (even if a
//                  pop happens on the same edge)
//   i_pop        : consume head entry; ignored while empty
//   o_dout       : head entry, valid whenever o_empty is low (zero when empty)
//   o_full/o_empty/o_level : registered occupancy, 0..2^AW
module vid2axis_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int AW    = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    // Full is judged on the current level only: no write-through on a
    // simultaneous pop, so a push at full is always dropped.
    assign w_wr_en = i_push & ~w_full;
    assign w_rd_en = i_pop & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Memory is not reset, so mask the head while empty to keep outputs clean.
    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/video_in_to_axi4_stream.sv
// Parallel video input (vsync / de / data) to AXI4-Stream master.
// Ports:
//   video_clk, video_rst        : sole clock, synchronous active-high reset
//   video_vsync_i               : rising edge starts a frame
//   video_de_i, video_data_i    : pixel qualifier and pixel
//   m_axis_tdata/tvalid/tready  : stream output
//   m_axis_tlast                : last pixel of a line
//   m_axis_tuser                : first pixel of a frame
//   fifo_level                  : FIFO occupancy, 0..2^FIFO_AW
//   overflow                    : sticky pixel-dropped flag, cleared by reset
//   dbg_state                   : capture FSM state
// Handshake: a beat transfers on a clock edge where tvalid and tready are
// both high; while tvalid is high and tready low, tdata/tlast/tuser are held.
module video_in_to_axi4_stream
    import vid2axis_pkg::*;
#(
    parameter int DW      = 32,
    parameter int FIFO_AW = 9
) (
    input  logic              video_clk,
    input  logic              video_rst,
    input  logic              video_vsync_i,
    input  logic              video_de_i,
    input  logic [DW-1:0]     video_data_i,
    output logic [DW-1:0]     m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    output state_t            dbg_state
);

    localparam int EW      = entry_w(DW);
    localparam int TLAST_B = tlast_bit(DW);
    localparam int TUSER_B = tuser_bit(DW);

    // Input stage
    logic          r_vs;
    logic          r_vs2;
    logic          r_de;
    logic [DW-1:0] r_data;

    // Hold register: one pixel of look-ahead so the last pixel of a line
    // can be tagged once DE is seen low.
    logic [DW-1:0] r_hold;
    logic          r_hold_v;
    logic          r_sof;
    logic          r_overflow;
    state_t        r_state;

    state_t        w_state_nxt;
    logic          w_vs_rise;
    logic          w_push;
    logic          w_hold_ld;
    logic          w_hold_v_nxt;
    logic          w_sof_nxt;
    logic          w_ovf_nxt;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [EW-1:0] w_din;
    logic [EW-1:0] w_dout;

    assign w_vs_rise = r_vs & ~r_vs2;

    // In RUN a held pixel is always written: either the next pixel replaces
    // it (tlast=0) or DE has dropped and it closes the line (tlast=1).
    assign w_din = {r_sof, ~r_de, r_hold};

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_hold_ld    = 1'b0;
        w_hold_v_nxt = 1'b0;
        w_sof_nxt    = r_sof;
        w_ovf_nxt    = r_overflow;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_RUN;
                    w_sof_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                w_push = r_hold_v;
                if (r_hold_v && w_fifo_full) begin
                    // Pixel lost: stop capturing until the next frame.
                    w_ovf_nxt   = 1'b1;
                    w_state_nxt = ST_DROP;
                end else begin
                    if (r_de) begin
                        w_hold_ld    = 1'b1;
                        w_hold_v_nxt = 1'b1;
                    end
                    if (r_hold_v) begin
                        w_sof_nxt = 1'b0;
                    end
                    // A new frame start wins over the write that consumed
                    // the old flag, so it tags the following write.
                    if (w_vs_rise) begin
                        w_sof_nxt = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_RUN;
                    w_sof_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (video_rst) begin
            r_vs       <= 1'b0;
            r_vs2      <= 1'b0;
            r_de       <= 1'b0;
            r_data     <= '0;
            r_hold     <= '0;
            r_hold_v   <= 1'b0;
            r_sof      <= 1'b0;
            r_overflow <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_vs       <= video_vsync_i;
            r_vs2      <= r_vs;
            r_de       <= video_de_i;
            r_data     <= video_data_i;
            if (w_hold_ld) begin
                r_hold <= r_data;
            end
            r_hold_v   <= w_hold_v_nxt;
            r_sof      <= w_sof_nxt;
            r_overflow <= w_ovf_nxt;
            r_state    <= w_state_nxt;
        end
    end

    vid2axis_sync_fifo #(
        .WIDTH (EW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk   (video_clk),
        .i_rst   (video_rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (m_axis_tready),
        .o_dout  (w_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign m_axis_tvalid = ~w_fifo_empty;
    assign m_axis_tdata  = w_dout[DW-1:0];
    assign m_axis_tlast  = w_dout[TLAST_B];
    assign m_axis_tuser  = w_dout[TUSER_B];
    assign overflow      = r_overflow;
    assign dbg_state     = r_state;

endmodule
